// File: rtl/read_if_pkg.sv
`default_nettype none
// ============================================================================
// read_if_pkg : shared read-side types and ID helpers for masters/arbiter/xbar
// Revision    : 1.0
// ============================================================================
package read_if_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DROP = 2'd2
   } rm_state_t;

   // Field widths are clamped to at least one bit so single-entry configs still elaborate
   function automatic int calc_iw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int calc_mw(input int m);
      return (m > 1) ? $clog2(m) : 1;
   endfunction

   function automatic logic id_is_master(input logic [31:0] id, input int iw, input int master);
      return (id >> iw) == $unsigned(master);
   endfunction

   function automatic logic [31:0] id_trans(input logic [31:0] id, input int iw);
      return id & ((32'd1 << iw) - 32'd1);
   endfunction

   function automatic logic [31:0] id_make(input int master, input logic [31:0] trans, input int iw);
      return ($unsigned(master) << iw) | trans;
   endfunction

endpackage
`default_nettype wire

// File: rtl/read_master_port_if.sv
`default_nettype none
// ============================================================================
// read_master_port_if : local request/response plus AR/R channel bundle
// Revision            : 1.0
// ============================================================================
interface read_master_port_if
   import read_if_pkg::*;
#(
   parameter int M                     = 2,
   parameter int NUM_OUTSTANDING_TRANS = 2,
   parameter int ADDR_WIDTH            = 32,
   parameter int DATA_WIDTH            = 32
);
   localparam int c_mw = calc_mw(M);
   localparam int c_iw = calc_iw(NUM_OUTSTANDING_TRANS);

   logic                   req_valid;
   logic [ADDR_WIDTH-1:0]  req_addr;
   logic                   req_ready;
   logic                   AR_request;
   logic [ADDR_WIDTH-1:0]  AR_addr;
   logic [c_iw-1:0]        AR_id;
   logic                   AR_grant;
   logic                   ARVALID;
   logic [ADDR_WIDTH-1:0]  ARADDR;
   logic [c_mw+c_iw-1:0]   ARID;
   logic                   ARREADY;
   logic                   RVALID;
   logic [DATA_WIDTH-1:0]  RDATA;
   logic [c_mw+c_iw-1:0]   RID;
   logic                   RLAST;
   logic                   RREADY;
   logic                   rsp_valid;
   logic [DATA_WIDTH-1:0]  rsp_data;
   logic [c_iw-1:0]        rsp_id;
   logic                   rsp_last;
   logic                   rsp_ready;
   logic                   rsp_err;

   modport master (
      input  req_valid, req_addr, AR_grant, ARREADY, RVALID, RDATA, RID, RLAST, rsp_ready,
      output req_ready, AR_request, AR_addr, AR_id, ARVALID, ARADDR, ARID, RREADY,
             rsp_valid, rsp_data, rsp_id, rsp_last, rsp_err
   );

   modport slave (
      output req_valid, req_addr, AR_grant, ARREADY, RVALID, RDATA, RID, RLAST, rsp_ready,
      input  req_ready, AR_request, AR_addr, AR_id, ARVALID, ARADDR, ARID, RREADY,
             rsp_valid, rsp_data, rsp_id, rsp_last, rsp_err
   );

endinterface
`default_nettype wire

// File: rtl/id_alloc.sv
`default_nettype none
// ============================================================================
// id_alloc : outstanding-ID busy vector with lowest-free-first allocation
// Revision : 1.0
// ============================================================================
module id_alloc #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  wire logic          clk,
   input  wire logic          clr,
   input  wire logic          i_alloc,
   input  wire logic          i_rel,
   input  wire logic [IW-1:0] i_rel_id,
   output logic [IW-1:0]      o_alloc_id,
   output logic               o_any_free,
   output logic [N-1:0]       o_busy
);
   localparam logic [N-1:0] c_one = {{(N-1){1'b0}}, 1'b1};

   logic [N-1:0]  r_busy;
   logic [N-1:0]  w_alloc_mask;
   logic [N-1:0]  w_rel_mask;
   logic [IW-1:0] w_free_id;
   logic          w_any_free;

   // Descending scan so the last hit, the lowest free index, wins
   always_comb begin
      w_free_id  = '0;
      w_any_free = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (!r_busy[i]) begin
            w_free_id  = IW'(i);
            w_any_free = 1'b1;
         end
      end
   end

   assign w_alloc_mask = i_alloc ? (c_one << w_free_id) : '0;
   assign w_rel_mask   = i_rel   ? (c_one << i_rel_id)  : '0;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_busy <= '0;
      end else begin
         r_busy <= (r_busy | w_alloc_mask) & ~w_rel_mask;
      end
   end

   assign o_alloc_id = w_free_id;
   assign o_any_free = w_any_free;
   assign o_busy     = r_busy;

endmodule
`default_nettype wire

// File: rtl/read_master_port.sv
`default_nettype none
// ============================================================================
// read_master_port : per-master read front end (ID alloc, AR request, R capture)
// Revision         : 1.0
// ============================================================================
module read_master_port
   import read_if_pkg::*;
#(
   parameter int M                     = 2,
   parameter int MASTER_ID             = 0,
   parameter int NUM_OUTSTANDING_TRANS = 2,
   parameter int ADDR_WIDTH            = 32,
   parameter int DATA_WIDTH            = 32
) (
   input  wire logic          clk,
   input  wire logic          clr,
   read_master_port_if.master bus
);
   localparam int c_mw = calc_mw(M);
   localparam int c_iw = calc_iw(NUM_OUTSTANDING_TRANS);
   localparam int c_n  = NUM_OUTSTANDING_TRANS;
   localparam logic [c_mw-1:0] c_master = MASTER_ID[c_mw-1:0];

   rm_state_t             r_state;
   rm_state_t             w_state_next;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [c_iw-1:0]       r_id;
   logic                  w_req_ready;
   logic                  w_ar_request;
   logic                  w_arvalid;
   logic                  w_accept;

   logic [c_iw-1:0]       w_alloc_id;
   logic                  w_any_free;
   logic [c_n-1:0]        w_busy;
   logic [(1<<c_iw)-1:0]  w_busy_ext;

   logic                  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_data;
   logic [c_iw-1:0]       r_rsp_id;
   logic                  r_rsp_last;
   logic                  r_rsp_err;
   logic                  w_rready;
   logic                  w_rid_mine;
   logic [c_iw-1:0]       w_rid_trans;
   logic                  w_beat_fire;
   logic                  w_beat_ok;
   logic                  w_release;

   assign w_accept = bus.req_valid && w_req_ready;

   id_alloc #(
      .N  (c_n),
      .IW (c_iw)
   ) u_id_alloc (
      .clk        (clk),
      .clr        (clr),
      .i_alloc    (w_accept),
      .i_rel      (w_release),
      .i_rel_id   (w_rid_trans),
      .o_alloc_id (w_alloc_id),
      .o_any_free (w_any_free),
      .o_busy     (w_busy)
   );

   // Non power-of-two ID counts: unused ID codes read as never busy
   generate
      if ((1 << c_iw) == c_n) begin : g_busy_exact
         assign w_busy_ext = w_busy;
      end else begin : g_busy_pad
         assign w_busy_ext = {{((1 << c_iw) - c_n){1'b0}}, w_busy};
      end
   endgenerate

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_state_next = ST_REQ;
         ST_REQ:  if (bus.AR_grant && bus.ARREADY) w_state_next = ST_DROP;
         ST_DROP: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // DROP deasserts the request for one cycle so the arbiter re-arbitrates
   always_comb begin
      w_req_ready  = 1'b0;
      w_ar_request = 1'b0;
      w_arvalid    = 1'b0;
      case (r_state)
         ST_IDLE: w_req_ready = w_any_free;
         ST_REQ: begin
            w_ar_request = 1'b1;
            w_arvalid    = bus.AR_grant;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_addr <= '0;
         r_id   <= '0;
      end else if (w_accept) begin
         r_addr <= bus.req_addr;
         r_id   <= w_alloc_id;
      end
   end

   assign w_rready    = !r_rsp_valid || bus.rsp_ready;
   assign w_rid_mine  = id_is_master(32'(bus.RID), c_iw, MASTER_ID);
   assign w_rid_trans = bus.RID[c_iw-1:0];
   assign w_beat_fire = bus.RVALID && w_rready;
   assign w_beat_ok   = w_beat_fire && w_rid_mine && w_busy_ext[w_rid_trans];
   assign w_release   = w_beat_ok && bus.RLAST;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_id    <= '0;
         r_rsp_last  <= 1'b0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_rsp_err <= w_beat_fire && !w_beat_ok;
         if (w_beat_ok) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= bus.RDATA;
            r_rsp_id    <= w_rid_trans;
            r_rsp_last  <= bus.RLAST;
         end else if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   assign bus.req_ready  = w_req_ready;
   assign bus.AR_request = w_ar_request;
   assign bus.AR_addr    = r_addr;
   assign bus.AR_id      = r_id;
   assign bus.ARVALID    = w_arvalid;
   assign bus.ARADDR     = r_addr;
   assign bus.ARID       = {c_master, r_id};
   assign bus.RREADY     = w_rready;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_data   = r_rsp_data;
   assign bus.rsp_id     = r_rsp_id;
   assign bus.rsp_last   = r_rsp_last;
   assign bus.rsp_err    = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_read_master_port.sv
`default_nettype none
// ============================================================================
// tb_read_master_port : directed + randomized bench with scoreboard model
// Revision            : 1.0
// ============================================================================
module tb_read_master_port;

   logic clk;
   logic clr;

   read_master_port_if #(
      .M(2), .NUM_OUTSTANDING_TRANS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)
   ) bus ();

   read_master_port #(
      .M(2), .MASTER_ID(0), .NUM_OUTSTANDING_TRANS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)
   ) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass     = 0;
   int n_total    = 0;
   int n_fail     = 0;
   int hs_count   = 0;
   int n_consumed = 0;

   // Reference model: set of outstanding IDs and the one-deep response holding slot
   bit          m_busy [2];
   bit          m_hold;
   logic [31:0] m_data;
   logic        m_id;
   logic        m_last;

   always @(posedge clk) if (bus.ARVALID && bus.ARREADY) hs_count <= hs_count + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int lowest_free();
      for (int i = 0; i < 2; i++) if (!m_busy[i]) return i;
      return -1;
   endfunction

   function automatic int n_free();
      return (m_busy[0] ? 0 : 1) + (m_busy[1] ? 0 : 1);
   endfunction

   task automatic do_read(input logic [31:0] addr, input bit withdraw);
      int   exp_id;
      int   hs0;
      logic e;
      exp_id = lowest_free();
      e = exp_id[0];
      bus.req_valid = 1'b1;
      bus.req_addr  = addr;
      #1;
      chk("req_ready_free", bus.req_ready, 1);
      step();
      bus.req_valid = 1'b0;
      m_busy[e] = 1'b1;
      hs0 = hs_count;
      #1;
      chk("ar_request_rise", bus.AR_request, 1);
      chk("ar_id", bus.AR_id, e);
      chk("ar_addr", bus.AR_addr, addr);
      chk("arvalid_nogrant", bus.ARVALID, 0);
      step();
      step();
      if (withdraw) begin
         bus.AR_grant = 1'b1;
         bus.ARREADY  = 1'b0;
         #1;
         chk("arvalid_grant_noready", bus.ARVALID, 1);
         step();
         bus.AR_grant = 1'b0;
         #1;
         chk("arvalid_withdrawn1", bus.ARVALID, 0);
         chk("ar_request_held1", bus.AR_request, 1);
         step();
         chk("arvalid_withdrawn2", bus.ARVALID, 0);
         chk("ar_request_held2", bus.AR_request, 1);
         step();
      end
      bus.AR_grant = 1'b1;
      bus.ARREADY  = 1'b1;
      #1;
      chk("arvalid_grant", bus.ARVALID, 1);
      chk("arid", bus.ARID, {1'b0, e});
      chk("araddr", bus.ARADDR, addr);
      step();
      bus.AR_grant = 1'b0;
      bus.ARREADY  = 1'b0;
      #1;
      chk("drop_ar_request", bus.AR_request, 0);
      chk("drop_req_ready", bus.req_ready, 0);
      chk("ar_handshakes", hs_count - hs0, 1);
      step();
      chk("idle_ar_request", bus.AR_request, 0);
      chk("idle_req_ready", bus.req_ready, n_free() > 0);
   endtask

   task automatic r_cycle(input bit v, input logic [1:0] rid, input bit last, input bit rdy,
                          output bit acc);
      logic [31:0] d;
      bit          exp_rr;
      bit          ok;
      d = $urandom;
      bus.RVALID    = v;
      bus.RID       = rid;
      bus.RDATA     = d;
      bus.RLAST     = last;
      bus.rsp_ready = rdy;
      #1;
      exp_rr = !m_hold || rdy;
      chk("rready", bus.RREADY, exp_rr);
      if (m_hold && rdy) begin
         chk("rsp_data", bus.rsp_data, m_data);
         chk("rsp_id", bus.rsp_id, m_id);
         chk("rsp_last", bus.rsp_last, m_last);
         n_consumed++;
      end
      acc = v && exp_rr;
      ok  = acc && (rid[1] == 1'b0) && m_busy[rid[0]];
      step();
      if (ok) begin
         m_hold = 1'b1;
         m_data = d;
         m_id   = rid[0];
         m_last = last;
         if (last) m_busy[rid[0]] = 1'b0;
      end else if (rdy) begin
         m_hold = 1'b0;
      end
      chk("rsp_valid", bus.rsp_valid, m_hold);
      chk("rsp_err", bus.rsp_err, acc && !ok);
      bus.RVALID = 1'b0;
   endtask

   initial begin
      bit acc;
      int sent;
      int cyc;
      int c0;

      clr = 1'b1;
      bus.req_valid = 0; bus.req_addr = 0; bus.AR_grant = 0; bus.ARREADY = 0;
      bus.RVALID = 0; bus.RDATA = 0; bus.RID = 0; bus.RLAST = 0; bus.rsp_ready = 1;
      m_busy[0] = 0; m_busy[1] = 0; m_hold = 0; m_data = 0; m_id = 0; m_last = 0;
      repeat (2) @(posedge clk);
      #1;
      clr = 1'b0;
      step();
      chk("rst_req_ready", bus.req_ready, 1);
      chk("rst_ar_request", bus.AR_request, 0);
      chk("rst_arvalid", bus.ARVALID, 0);
      chk("rst_araddr", bus.ARADDR, 0);
      chk("rst_arid", bus.ARID, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_err", bus.rsp_err, 0);
      chk("rst_rready", bus.RREADY, 1);

      // Single read, then a second one fills both IDs
      do_read(32'h0000_1000, 1'b0);
      do_read($urandom, 1'b0);
      bus.req_valid = 1'b1;
      #1;
      chk("full_req_ready", bus.req_ready, 0);
      step();
      chk("full_no_request", bus.AR_request, 0);
      bus.req_valid = 1'b0;

      // Release ID 0 and reissue it
      r_cycle(1'b1, 2'b00, 1'b1, 1'b1, acc);
      chk("release_req_ready", bus.req_ready, 1);
      r_cycle(1'b0, 2'b00, 1'b0, 1'b1, acc);
      do_read($urandom, 1'b0);

      // Four-beat burst on ID 1 with rsp_ready cycling 1,0,1
      c0 = n_consumed;
      sent = 0;
      cyc  = 0;
      while (sent < 4 && cyc < 40) begin
         r_cycle(1'b1, 2'b01, sent == 3, (cyc % 3) != 1, acc);
         if (acc) sent++;
         cyc++;
      end
      chk("burst_sent", sent, 4);
      repeat (2) r_cycle(1'b0, 2'b00, 1'b0, 1'b1, acc);
      chk("burst_consumed", n_consumed - c0, 4);

      // Stray beats: foreign master, then a non-busy ID
      r_cycle(1'b1, 2'b10, 1'b1, 1'b1, acc);
      r_cycle(1'b0, 2'b00, 1'b0, 1'b1, acc);
      r_cycle(1'b1, 2'b01, 1'b1, 1'b1, acc);
      r_cycle(1'b0, 2'b00, 1'b0, 1'b1, acc);
      chk("stray_req_ready", bus.req_ready, 1);

      // Randomized R traffic against the model
      for (int i = 0; i < 60; i++) begin
         r_cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0, acc);
      end
      repeat (2) r_cycle(1'b0, 2'b00, 1'b0, 1'b1, acc);

      // Grant withdrawn before the handshake
      do_read($urandom, 1'b1);

      // Bring busy to exactly one free ID, then reset while in REQ with busy=11
      if (n_free() == 0) begin
         r_cycle(1'b1, 2'b00, 1'b1, 1'b1, acc);
         r_cycle(1'b0, 2'b00, 1'b0, 1'b1, acc);
      end
      while (n_free() > 1) do_read($urandom, 1'b0);
      r_cycle(1'b1, {1'b0, m_busy[0] ? 1'b0 : 1'b1}, 1'b0, 1'b0, acc);
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'hDEAD_BEEF;
      #1;
      chk("last_free_ready", bus.req_ready, 1);
      step();
      bus.req_valid = 1'b0;
      bus.AR_grant  = 1'b1;
      #1;
      chk("pre_clr_arvalid", bus.ARVALID, 1);
      chk("pre_clr_rsp_valid", bus.rsp_valid, 1);
      chk("pre_clr_req_ready", bus.req_ready, 0);
      #2;
      clr = 1'b1;
      #1;
      chk("clr_ar_request", bus.AR_request, 0);
      chk("clr_arvalid", bus.ARVALID, 0);
      chk("clr_ar_addr", bus.AR_addr, 0);
      chk("clr_ar_id", bus.AR_id, 0);
      chk("clr_arid", bus.ARID, 0);
      chk("clr_rsp_valid", bus.rsp_valid, 0);
      chk("clr_rsp_data", bus.rsp_data, 0);
      chk("clr_rready", bus.RREADY, 1);
      chk("clr_req_ready", bus.req_ready, 1);
      bus.AR_grant  = 1'b0;
      bus.rsp_ready = 1'b1;
      m_busy[0] = 0; m_busy[1] = 0; m_hold = 0;
      step();
      clr = 1'b0;
      step();
      chk("post_clr_req_ready", bus.req_ready, 1);
      do_read($urandom, 1'b0);
      r_cycle(1'b1, 2'b01, 1'b1, 1'b1, acc);
      r_cycle(1'b1, 2'b00, 1'b1, 1'b1, acc);
      r_cycle(1'b0, 2'b00, 1'b0, 1'b1, acc);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
